// File: rtl/csadd_mp_sequencer_pkg.sv
// Shared types and sizing helpers for the word-serial carry-select add/sub sequencer.
package csadd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned W = 32;

  // Beat counter must be able to hold MAX_WORDS itself.
  function automatic int unsigned cnt_width(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/csadd_mp_sequencer_csadd.sv
// Byte-sliced carry-select adder: each byte precomputes both carry-in cases, the chain only muxes.
module CSAdder #(
  parameter int unsigned BYTES = 4
) (
  input  logic                 cin,
  input  logic [BYTES*8-1:0]   a,
  input  logic [BYTES*8-1:0]   b,
  output logic [BYTES*8-1:0]   q,
  output logic                 cout
);

  logic [BYTES:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < BYTES; g++) begin : g_byte
    logic [8:0] s0;
    logic [8:0] s1;
    assign s0 = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]};
    assign s1 = s0 + 9'd1;
    assign q[g*8 +: 8] = c[g] ? s1[7:0] : s0[7:0];
    assign c[g+1]      = c[g] ? s1[8]   : s0[8];
  end

  assign cout = c[BYTES];

endmodule

// File: rtl/csadd_mp_sequencer.sv
// Word-serial multi-precision add/subtract: LS word first, carry chained in a register, 1-cycle latency.
module csadd_mp_sequencer
  import csadd_pkg::*;
#(
  parameter int unsigned BYTES     = 4,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BYTES*8-1:0]   in_a,
  input  logic [BYTES*8-1:0]   in_b,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BYTES*8-1:0]   out_q,
  output logic                 out_last,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 err
);

  localparam int unsigned DW = BYTES * 8;
  localparam int unsigned CW = cnt_width(MAX_WORDS);

  state_t          state;
  logic            carry_q;
  logic            sub_q;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            is_first;
  logic            sub_eff;
  logic            cin;
  logic [DW-1:0]   b_eff;
  logic [DW-1:0]   q;
  logic            cout;
  logic            ovf;
  logic [CW-1:0]   cnt_nxt;
  logic            hit_max;
  logic            drive_last;
  logic            proto_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // In IDLE every beat is a first word; in RUN an unexpected first aborts and restarts.
  always_comb begin
    is_first   = (state == IDLE) || in_first;
    sub_eff    = is_first ? in_sub : sub_q;
    cin        = is_first ? in_sub : carry_q;
    b_eff      = sub_eff ? ~in_b : in_b;
    cnt_nxt    = is_first ? CW'(1) : cnt + CW'(1);
    hit_max    = (cnt_nxt == CW'(MAX_WORDS)) && !in_last;
    drive_last = in_last || hit_max;
    proto_err  = ((state == IDLE) && !in_first) || ((state == RUN) && in_first) || hit_max;
    ovf        = (in_a[DW-1] == b_eff[DW-1]) && (q[DW-1] != in_a[DW-1]);
  end

  CSAdder #(.BYTES(BYTES)) u_csadd (
    .cin  (cin),
    .a    (in_a),
    .b    (b_eff),
    .q    (q),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        carry_q   <= cout;
        sub_q     <= sub_eff;
        cnt       <= cnt_nxt;
        state     <= drive_last ? IDLE : RUN;
        out_valid <= 1'b1;
        out_q     <= q;
        out_last  <= drive_last;
        if (drive_last) begin
          out_cout <= cout;
          out_ovf  <= ovf;
        end
        if (proto_err) err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csadd_mp_sequencer.sv
// Directed-vector bench for csadd_mp_sequencer (BYTES=4, MAX_WORDS=4).
module tb_csadd_mp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_first;
  logic        in_last;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        err;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  csadd_mp_sequencer #(.BYTES(4), .MAX_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, leave #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic f, input logic l, input logic s);
    bit ok;
    in_a = a; in_b = b; in_first = f; in_last = l; in_sub = s;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] q, input logic last);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_q"},     {32'd0, out_q},     {32'd0, q});
    check({tag, "_last"},  {63'd0, out_last},  {63'd0, last});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    #23;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_q",     {32'd0, out_q},     64'd0);
    check("rst_out_last",  {63'd0, out_last},  64'd0);
    check("rst_out_cout",  {63'd0, out_cout},  64'd0);
    check("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
    check("rst_err",       {63'd0, err},       64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. single-word add with carry out
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0);
    expect_out("t1", 32'h00000000, 1'b1);
    check("t1_cout", {63'd0, out_cout}, 64'd1);
    check("t1_ovf",  {63'd0, out_ovf},  64'd0);
    check("t1_err",  {63'd0, err},      64'd0);

    // 2. three-word add, carry ripples across both lower words
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0);
    expect_out("t2w0", 32'h00000000, 1'b0);
    send(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0);
    expect_out("t2w1", 32'h00000000, 1'b0);
    send(32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0);
    expect_out("t2w2", 32'h00000002, 1'b1);
    check("t2_cout", {63'd0, out_cout}, 64'd0);
    check("t2_ovf",  {63'd0, out_ovf},  64'd0);

    // 3. two-word sub 0 - 1: borrow propagates
    send(32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b1);
    expect_out("t3w0", 32'hFFFFFFFF, 1'b0);
    send(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0);
    expect_out("t3w1", 32'hFFFFFFFF, 1'b1);
    check("t3_cout", {63'd0, out_cout}, 64'd0);
    check("t3_ovf",  {63'd0, out_ovf},  64'd0);

    // 4. backpressure mid-operation
    send(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    expect_out("t4w0", 32'h00000000, 1'b0);
    out_ready = 1'b0;
    in_a = 32'h80000000; in_b = 32'h80000000; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_bp_in_ready", {63'd0, in_ready},  64'd0);
      check("t4_bp_valid",    {63'd0, out_valid}, 64'd1);
      check("t4_bp_q",        {32'd0, out_q},     64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    expect_out("t4w1", 32'h00000001, 1'b0);
    in_a = 32'h00000000; in_b = 32'h00000000; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("t4w2", 32'h00000001, 1'b1);
    check("t4_cout", {63'd0, out_cout}, 64'd0);
    @(posedge clk); #1;
    check("t4_drain_valid", {63'd0, out_valid}, 64'd0);

    // 6a. signed overflow on a single word
    send(32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0);
    expect_out("t6", 32'h80000000, 1'b1);
    check("t6_ovf",  {63'd0, out_ovf},  64'd1);
    check("t6_cout", {63'd0, out_cout}, 64'd0);
    check("t6_err",  {63'd0, err},      64'd0);

    // 5a. first=1 inside RUN aborts; stale carry must not leak into the restart
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0);
    expect_out("t5a_w0", 32'h00000000, 1'b0);
    check("t5a_err_before", {63'd0, err}, 64'd0);
    send(32'h00000005, 32'h00000003, 1'b1, 1'b1, 1'b0);
    expect_out("t5a_restart", 32'h00000008, 1'b1);
    check("t5a_cout", {63'd0, out_cout}, 64'd0);
    check("t5a_err",  {63'd0, err},      64'd1);

    // 5b. length limit: beat 4 is forced last, beat 5 starts a new operation
    send(32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
    expect_out("t5b_b1", 32'h2, 1'b0);
    send(32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_out("t5b_b2", 32'h2, 1'b0);
    send(32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_out("t5b_b3", 32'h2, 1'b0);
    send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_out("t5b_b4", 32'h0, 1'b1);
    check("t5b_b4_cout", {63'd0, out_cout}, 64'd1);
    send(32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_out("t5b_b5", 32'h2, 1'b0);
    check("t5b_err", {63'd0, err}, 64'd1);

    // 6b. async reset mid-RUN, then a first=0 beat is still handled as a first word
    #3;
    rst_n = 1'b0;
    #1;
    check("t6b_rst_valid",    {63'd0, out_valid}, 64'd0);
    check("t6b_rst_err",      {63'd0, err},       64'd0);
    check("t6b_rst_in_ready", {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0);
    expect_out("t6b_after", 32'h00000008, 1'b1);
    check("t6b_err", {63'd0, err}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
